// File: rtl/mnk_game_core.sv
// mnk_game_core: N x N board engine with K-in-a-row win detection.
// Accepts one move per PLAY visit, rejects occupied/out-of-range cells,
// then spends a fixed four cycles (one per line direction) deciding the
// outcome before handing the turn over or finishing the game.
module mnk_game_core #(
    parameter int N    = 3,
    parameter int K    = 3,
    parameter int IDXW = $clog2(N*N)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       move_valid,
    input  logic [IDXW-1:0]            move_idx,
    output logic                       move_ready,
    output logic                       move_reject,
    output logic [2*N*N-1:0]           board,
    output logic                       turn,
    output logic [1:0]                 result,
    output logic [$clog2(N*N+1)-1:0]   move_count,
    output logic                       busy
);

    localparam int CELLS = N * N;
    localparam int CW    = $clog2(N*N+1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [1:0]        dir;
    logic              win_flag;
    logic [IDXW-1:0]   last_idx;

    logic [1:0]        mover_code;
    logic              cell_free;
    logic [2*N*N-1:0]  board_placed;
    logic [CELLS-1:0]  own;
    int                last_row;
    int                last_col;
    int                step_dr;
    int                step_dc;
    int                run;
    logic              dir_win;
    logic              win_any;

    // Stone code written for the side to move.
    function automatic logic [1:0] stone_of(input logic side);
        if (side) begin
            return 2'b10;
        end else begin
            return 2'b01;
        end
    endfunction

    // True when (r, c) lies on the board; used to stop runs at the edges.
    function automatic logic on_board(input int r, input int c);
        return (r >= 0) && (r < N) && (c >= 0) && (c < N);
    endfunction

    // Length of the line through (r0, c0) along (dr, dc), counting at most
    // K-1 steps each way. Row/column bounds are checked separately so a
    // step never wraps from the end of one row onto the next.
    function automatic int run_len(input logic [CELLS-1:0] own_v,
                                   input int r0, input int c0,
                                   input int dr, input int dc);
        int   len;
        int   rr;
        int   cc;
        logic go;
        len = 1;
        go  = 1'b1;
        for (int s = 1; s < K; s++) begin
            rr = r0 + s * dr;
            cc = c0 + s * dc;
            if (go && on_board(rr, cc)) begin
                if (own_v[IDXW'(rr * N + cc)]) begin
                    len = len + 1;
                end else begin
                    go = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
        go = 1'b1;
        for (int s = 1; s < K; s++) begin
            rr = r0 - s * dr;
            cc = c0 - s * dc;
            if (go && on_board(rr, cc)) begin
                if (own_v[IDXW'(rr * N + cc)]) begin
                    len = len + 1;
                end else begin
                    go = 1'b0;
                end
            end else begin
                go = 1'b0;
            end
        end
        return len;
    endfunction

    // Legality of the offered cell and the board as it would look after placing it.
    always_comb begin
        mover_code   = stone_of(turn);
        cell_free    = 1'b0;
        board_placed = board;
        for (int i = 0; i < CELLS; i++) begin
            if (move_idx == IDXW'(i)) begin
                cell_free                = (board[2*i +: 2] == 2'b00);
                board_placed[2*i +: 2]   = mover_code;
            end else begin
                board_placed[2*i +: 2]   = board[2*i +: 2];
            end
        end
    end

    // Ownership map of the mover's stones, used by the line scan.
    always_comb begin
        own = '0;
        for (int i = 0; i < CELLS; i++) begin
            own[i] = (board[2*i +: 2] == mover_code);
        end
    end

    // Step vector for the direction being evaluated this CHECK cycle.
    always_comb begin
        case (dir)
            2'd0: begin step_dr = 0; step_dc = 1;  end
            2'd1: begin step_dr = 1; step_dc = 0;  end
            2'd2: begin step_dr = 1; step_dc = 1;  end
            2'd3: begin step_dr = 1; step_dc = -1; end
            default: begin step_dr = 0; step_dc = 1; end
        endcase
    end

    // Run length through the last move in the current direction.
    always_comb begin
        last_row = int'(last_idx) / N;
        last_col = int'(last_idx) % N;
        run      = run_len(own, last_row, last_col, step_dr, step_dc);
        dir_win  = (run >= K);
        win_any  = win_flag | dir_win;
    end

    // Game FSM together with all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            board       <= '0;
            turn        <= 1'b0;
            result      <= 2'b00;
            move_count  <= '0;
            move_ready  <= 1'b0;
            move_reject <= 1'b0;
            busy        <= 1'b0;
            dir         <= 2'd0;
            win_flag    <= 1'b0;
            last_idx    <= '0;
        end else if (start) begin
            state       <= PLAY;
            board       <= '0;
            turn        <= 1'b0;
            result      <= 2'b00;
            move_count  <= '0;
            move_ready  <= 1'b1;
            move_reject <= 1'b0;
            busy        <= 1'b0;
            dir         <= 2'd0;
            win_flag    <= 1'b0;
        end else begin
            move_reject <= 1'b0;
            case (state)
                IDLE: begin
                    state <= IDLE;
                end
                PLAY: begin
                    if (move_valid) begin
                        if (cell_free) begin
                            board      <= board_placed;
                            move_count <= move_count + CW'(1);
                            last_idx   <= move_idx;
                            dir        <= 2'd0;
                            win_flag   <= 1'b0;
                            state      <= CHECK;
                            move_ready <= 1'b0;
                            busy       <= 1'b1;
                        end else begin
                            move_reject <= 1'b1;
                        end
                    end else begin
                        state <= PLAY;
                    end
                end
                CHECK: begin
                    win_flag <= win_any;
                    dir      <= dir + 2'd1;
                    if (dir == 2'd3) begin
                        busy <= 1'b0;
                        if (win_any) begin
                            result <= turn ? 2'b10 : 2'b01;
                            state  <= DONE;
                        end else if (move_count == CW'(CELLS)) begin
                            result <= 2'b11;
                            state  <= DONE;
                        end else begin
                            turn       <= ~turn;
                            state      <= PLAY;
                            move_ready <= 1'b1;
                        end
                    end else begin
                        state <= CHECK;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state      <= IDLE;
                    move_ready <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mnk_game_core.sv
// Scoreboard bench for mnk_game_core: stimulus pushes the expected
// post-move snapshot, monitors pop it on a reject pulse or when busy drops.
module tb_mnk_game_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start3, mv3, rdy3, rej3, turn3, busy3;
    logic [3:0]  idx3;
    logic [17:0] brd3;
    logic [1:0]  res3;
    logic [3:0]  cnt3;

    logic        start4, mv4, rdy4, rej4, turn4, busy4;
    logic [3:0]  idx4;
    logic [31:0] brd4;
    logic [1:0]  res4;
    logic [4:0]  cnt4;

    mnk_game_core #(.N(3), .K(3)) u3 (
        .clk(clk), .rst(rst), .start(start3), .move_valid(mv3), .move_idx(idx3),
        .move_ready(rdy3), .move_reject(rej3), .board(brd3), .turn(turn3),
        .result(res3), .move_count(cnt3), .busy(busy3)
    );

    mnk_game_core #(.N(4), .K(3)) u4 (
        .clk(clk), .rst(rst), .start(start4), .move_valid(mv4), .move_idx(idx4),
        .move_ready(rdy4), .move_reject(rej4), .board(brd4), .turn(turn4),
        .result(res4), .move_count(cnt4), .busy(busy4)
    );

    typedef struct {
        bit          rej;
        logic [1:0]  res;
        logic        trn;
        int          cnt;
        logic [31:0] brd;
        int          lat;
    } exp_t;

    exp_t q3[$];
    exp_t q4[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] eb [2];
    int          ec [2];
    logic        et [2];
    logic [1:0]  er [2];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endfunction

    // Monitor for the 3x3 instance
    int   bc3 = 0;
    logic pb3 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rej3 === 1'b1) begin
            if (q3.size() == 0) begin
                chk("unexpected_reject3", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                chk("kind_rej3", 32'(e.rej), 32'd1);
                chk("rej_ready3", 32'(rdy3), 32'd1);
                chk("rej_board3", 32'(brd3), e.brd);
                chk("rej_count3", 32'(cnt3), 32'(e.cnt));
                chk("rej_turn3", 32'(turn3), 32'(e.trn));
            end
        end
        if (pb3 && !busy3) begin
            if (q3.size() == 0) begin
                chk("unexpected_done3", 32'd1, 32'd0);
            end else begin
                e = q3.pop_front();
                chk("kind_done3", 32'(e.rej), 32'd0);
                chk("latency3", 32'(bc3), 32'(e.lat));
                chk("result3", 32'(res3), 32'(e.res));
                chk("turn3", 32'(turn3), 32'(e.trn));
                chk("count3", 32'(cnt3), 32'(e.cnt));
                chk("board3", 32'(brd3), e.brd);
            end
        end
        bc3 = busy3 ? bc3 + 1 : 0;
        pb3 = busy3;
    end

    // Monitor for the 4x4 instance
    int   bc4 = 0;
    logic pb4 = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rej4 === 1'b1) begin
            if (q4.size() == 0) begin
                chk("unexpected_reject4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("kind_rej4", 32'(e.rej), 32'd1);
                chk("rej_board4", brd4, e.brd);
                chk("rej_count4", 32'(cnt4), 32'(e.cnt));
            end
        end
        if (pb4 && !busy4) begin
            if (q4.size() == 0) begin
                chk("unexpected_done4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                chk("kind_done4", 32'(e.rej), 32'd0);
                chk("latency4", 32'(bc4), 32'(e.lat));
                chk("result4", 32'(res4), 32'(e.res));
                chk("turn4", 32'(turn4), 32'(e.trn));
                chk("count4", 32'(cnt4), 32'(e.cnt));
                chk("board4", brd4, e.brd);
            end
        end
        bc4 = busy4 ? bc4 + 1 : 0;
        pb4 = busy4;
    end

    task automatic drive(input int sel, input logic s, input logic v, input logic [3:0] idx);
        if (sel == 0) begin
            start3 = s; mv3 = v; idx3 = idx;
        end else begin
            start4 = s; mv4 = v; idx4 = idx;
        end
    endtask

    task automatic wait_ready(input int sel, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (((sel == 0) ? rdy3 : rdy4) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain(input int sel);
        for (int i = 0; i < 40; i++) begin
            if (((sel == 0) ? q3.size() : q4.size()) == 0) break;
            @(negedge clk);
        end
        chk("drain_timeout", 32'((sel == 0) ? q3.size() : q4.size()), 32'd0);
    endtask

    task automatic reset_model(input int sel);
        eb[sel] = '0; ec[sel] = 0; et[sel] = 1'b0; er[sel] = 2'b00;
    endtask

    // start pulse; 'now' means drive it on the current negedge
    task automatic do_start(input int sel, input bit now);
        if (!now) @(negedge clk);
        drive(sel, 1'b1, 1'b0, 4'd0);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 4'd0);
        reset_model(sel);
        chk("start_ready", 32'((sel == 0) ? rdy3 : rdy4), 32'd1);
        chk("start_turn", 32'((sel == 0) ? turn3 : turn4), 32'd0);
        chk("start_board", (sel == 0) ? 32'(brd3) : brd4, 32'd0);
        chk("start_result", 32'((sel == 0) ? res3 : res4), 32'd0);
    endtask

    // Offer a move; push the hand-computed outcome (result/turn after CHECK)
    task automatic mv(input int sel, input int idx, input bit legal,
                      input logic [1:0] res, input logic trn);
        exp_t e;
        bit ok;
        wait_ready(sel, ok);
        if (ok) begin
            if (legal) begin
                eb[sel][2*idx +: 2] = et[sel] ? 2'b10 : 2'b01;
                ec[sel] = ec[sel] + 1;
                er[sel] = res;
                et[sel] = trn;
            end
            e.rej = !legal;
            e.res = er[sel];
            e.trn = et[sel];
            e.cnt = ec[sel];
            e.brd = eb[sel];
            e.lat = 4;
            if (sel == 0) q3.push_back(e); else q4.push_back(e);
            drive(sel, 1'b0, 1'b1, 4'(idx));
            @(negedge clk);
            drive(sel, 1'b0, 1'b0, 4'd0);
        end
    endtask

    // Replace the last pushed 3x3 expectation with a cleared snapshot
    task automatic expect_cleared3(input int lat);
        exp_t e;
        e = q3.pop_back();
        e.rej = 1'b0; e.res = 2'b00; e.trn = 1'b0; e.cnt = 0; e.brd = '0; e.lat = lat;
        q3.push_back(e);
    endtask

    int dm [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int wm [9] = '{0, 1, 2, 3, 5, 4, 7, 6, 8};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 4'd0);
        drive(1, 1'b0, 1'b0, 4'd0);
        reset_model(0);
        reset_model(1);
        repeat (3) @(negedge clk);
        chk("rst_board3", 32'(brd3), 32'd0);
        chk("rst_turn3", 32'(turn3), 32'd0);
        chk("rst_result3", 32'(res3), 32'd0);
        chk("rst_count3", 32'(cnt3), 32'd0);
        chk("rst_ready3", 32'(rdy3), 32'd0);
        chk("rst_reject3", 32'(rej3), 32'd0);
        chk("rst_busy3", 32'(busy3), 32'd0);
        chk("rst_ready4", 32'(rdy4), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready3", 32'(rdy3), 32'd0);

        // Row win on the top row
        do_start(0, 1'b0);
        mv(0, 0, 1'b1, 2'b00, 1'b1);
        mv(0, 3, 1'b1, 2'b00, 1'b0);
        mv(0, 1, 1'b1, 2'b00, 1'b1);
        mv(0, 4, 1'b1, 2'b00, 1'b0);
        mv(0, 2, 1'b1, 2'b01, 1'b0);
        drain(0);
        chk("rowwin_top", 32'(brd3[5:0]), 32'b010101);
        drive(0, 1'b0, 1'b1, 4'd5);
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 4'd0);
        @(negedge clk);
        chk("done_ignore_board", 32'(brd3), eb[0]);
        chk("done_ignore_ready", 32'(rdy3), 32'd0);
        chk("done_ignore_result", 32'(res3), 32'b01);

        // Occupied and out-of-range cells
        do_start(0, 1'b0);
        mv(0, 4, 1'b1, 2'b00, 1'b1);
        mv(0, 4, 1'b0, 2'b00, 1'b1);
        mv(0, 9, 1'b0, 2'b00, 1'b1);
        drain(0);
        chk("occ_turn", 32'(turn3), 32'd1);
        chk("occ_count", 32'(cnt3), 32'd1);

        // Row wrap on 4x4: cells 2,3,4 must not form a line
        do_start(1, 1'b0);
        mv(1, 2, 1'b1, 2'b00, 1'b1);
        mv(1, 8, 1'b1, 2'b00, 1'b0);
        mv(1, 3, 1'b1, 2'b00, 1'b1);
        mv(1, 9, 1'b1, 2'b00, 1'b0);
        mv(1, 4, 1'b1, 2'b00, 1'b1);
        drain(1);

        // Draw
        do_start(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            mv(0, dm[i], 1'b1, (i == 8) ? 2'b11 : 2'b00,
               (i == 8) ? 1'b0 : ((i % 2 == 0) ? 1'b1 : 1'b0));
        end
        drain(0);

        // Win on the last free cell
        do_start(0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            mv(0, wm[i], 1'b1, (i == 8) ? 2'b01 : 2'b00,
               (i == 8) ? 1'b0 : ((i % 2 == 0) ? 1'b1 : 1'b0));
        end
        drain(0);
        chk("fullwin_count", 32'(cnt3), 32'd9);

        // start during CHECK, on the cycle after the accept
        do_start(0, 1'b0);
        mv(0, 4, 1'b1, 2'b00, 1'b1);
        expect_cleared3(1);
        do_start(0, 1'b1);
        drain(0);

        // rst during CHECK
        mv(0, 0, 1'b1, 2'b00, 1'b1);
        expect_cleared3(1);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        reset_model(0);
        reset_model(1);
        drain(0);
        chk("midrst_ready3", 32'(rdy3), 32'd0);
        chk("midrst_busy3", 32'(busy3), 32'd0);
        chk("midrst_board3", 32'(brd3), 32'd0);
        chk("midrst_count3", 32'(cnt3), 32'd0);
        chk("midrst_result3", 32'(res3), 32'd0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("final_busy3", 32'(busy3), 32'd0);
        chk("q3_empty", 32'(q3.size()), 32'd0);
        chk("q4_empty", 32'(q4.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
